// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the handshaking multicycle MIPS controller.
// Optional macro MC_CTRL_BNE_EN adds the BNE opcode constant.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_FETCH  = 5'd0,
        ST_DECODE = 5'd1,
        ST_RTYPE  = 5'd2,
        ST_ALUWB  = 5'd3,
        ST_ADDI   = 5'd4,
        ST_SLTI   = 5'd5,
        ST_ORI    = 5'd6,
        ST_IMMWB  = 5'd7,
        ST_BEQ    = 5'd8,
        ST_J      = 5'd9,
        ST_JAL    = 5'd10,
        ST_JR     = 5'd11,
        ST_MEMADR = 5'd12,
        ST_MEMRD  = 5'd13,
        ST_MEMWB  = 5'd14,
        ST_MEMWR  = 5'd15,
        ST_TRAP   = 5'd16,
        ST_BNE    = 5'd17
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] ASB_RT    = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_IMM   = 2'b10;
    localparam logic [1:0] ASB_IMMSH = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       alu_src_a;
        logic       ori;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic is_mem_state(state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; flags a timeout on the stall cycle that would
// bring the count of unanswered cycles up to MEM_TIMEOUT.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);
    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Every exit from a memory state passes through ready or timeout, so
    // clearing outside stalls also clears on entry to the next memory state.
    always_comb begin
        cnt_d = 8'd0;
        if (active_i && !ready_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = active_i && !ready_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// Multicycle MIPS main controller with memory ready handshake, wait timeout
// and illegal-opcode trap. Optional macro MC_CTRL_BNE_EN adds BNE support.
module mips_mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               ori,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         reg_dst,
    output logic [ALUOP_W-1:0] alu_op,
`ifdef MC_CTRL_BNE_EN
    output logic               branch_ne,
`endif
    output logic               trap,
    output logic [1:0]         trap_code
);

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       timeout;
    ctrl_t      ctrl_s, ctrl;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active_i  (is_mem_state(state_q)),
        .ready_i   (mem_ready),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            code_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        code_d            = code_q;
        ctrl_s            = '0;
        ctrl_s.alu_src_b  = ASB_RT;
        ctrl_s.pc_src     = PCS_ALU;
        ctrl_s.mem_to_reg = M2R_ALUOUT;
        ctrl_s.reg_dst    = RD_RT;
        ctrl_s.alu_op     = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.alu_src_b = ASB_FOUR;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    code_d  = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ctrl_s.alu_src_b = ASB_IMMSH;
                case (opcode)
                    OP_RTYPE:          state_d = (funct == FN_JR) ? ST_JR : ST_RTYPE;
                    OP_ADDI, OP_ADDIU: state_d = ST_ADDI;
                    OP_SLTI:           state_d = ST_SLTI;
                    OP_ORI:            state_d = ST_ORI;
                    OP_BEQ:            state_d = ST_BEQ;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:            state_d = ST_BNE;
`endif
                    OP_J:              state_d = ST_J;
                    OP_JAL:            state_d = ST_JAL;
                    OP_LW, OP_SW:      state_d = ST_MEMADR;
                    default: begin
                        state_d = ST_TRAP;
                        code_d  = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_RTYPE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_op    = ALU_FUNCT;
                state_d          = ST_ALUWB;
            end
            ST_ALUWB: begin
                ctrl_s.reg_dst   = RD_RD;
                ctrl_s.reg_write = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_ADDI, ST_SLTI, ST_ORI: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ASB_IMM;
                if (state_q == ST_SLTI) ctrl_s.alu_op = ALU_SLT;
                if (state_q == ST_ORI) begin
                    ctrl_s.alu_op = ALU_OR;
                    ctrl_s.ori    = 1'b1;
                end
                state_d = ST_IMMWB;
            end
            ST_IMMWB: begin
                ctrl_s.reg_write = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_BEQ, ST_BNE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_op    = ALU_SUB;
                ctrl_s.pc_src    = PCS_ALUOUT;
                ctrl_s.branch    = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_J, ST_JAL: begin
                ctrl_s.pc_src   = PCS_JUMP;
                ctrl_s.pc_write = 1'b1;
                if (state_q == ST_JAL) begin
                    ctrl_s.reg_dst    = RD_RA;
                    ctrl_s.mem_to_reg = M2R_PC;
                    ctrl_s.reg_write  = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_JR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.pc_src    = PCS_RS;
                ctrl_s.pc_write  = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ASB_IMM;
                state_d          = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD, ST_MEMWR: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.iord      = 1'b1;
                ctrl_s.mem_write = (state_q == ST_MEMWR);
                if (mem_ready) begin
                    state_d = (state_q == ST_MEMRD) ? ST_MEMWB : ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    code_d  = TRAP_TIMEOUT;
                end
            end
            ST_MEMWB: begin
                ctrl_s.mem_to_reg = M2R_MDR;
                ctrl_s.reg_write  = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset blanks the strobes combinationally so an in-flight access ends at once.
    assign ctrl = rst_n ? ctrl_s : '0;

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign ori        = ctrl.ori;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign alu_op     = ALUOP_W'(ctrl.alu_op);
`ifdef MC_CTRL_BNE_EN
    assign branch_ne  = rst_n && (state_q == ST_BNE);
`endif
    assign trap       = (state_q == ST_TRAP);
    assign trap_code  = code_q;

endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// Table-driven bench for mips_mc_ctrl_hs: per-cycle expected outputs are
// queued when inputs are driven and compared mid-cycle.
module tb_mips_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, mem_write, ir_write, pc_write, branch, reg_write;
    logic       alu_src_a, ori, trap;
    logic [1:0] alu_src_b, pc_src, mem_to_reg, reg_dst, trap_code;
    logic [2:0] alu_op;
    logic       branch_ne;

    int errors = 0;
    int checks = 0;

    mips_mc_ctrl_hs #(.ALUOP_W(3), .MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .ori        (ori),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_op     (alu_op),
`ifdef MC_CTRL_BNE_EN
        .branch_ne  (branch_ne),
`endif
        .trap       (trap),
        .trap_code  (trap_code)
    );

`ifndef MC_CTRL_BNE_EN
    assign branch_ne = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [22:0] act;
    assign act = {mem_req, iord, mem_write, ir_write, pc_write, branch, reg_write,
                  alu_src_a, ori, alu_src_b, pc_src, mem_to_reg, reg_dst, alu_op,
                  trap, trap_code};

    typedef enum {
        L_FETCH, L_DECODE, L_RTYPE, L_ALUWB, L_ADDI, L_SLTI, L_ORI, L_IMMWB,
        L_BEQ, L_BNE, L_J, L_JAL, L_JR, L_MEMADR, L_MEMRD, L_MEMWB, L_MEMWR,
        L_TRAP1, L_TRAP2, L_RST
    } lbl_e;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        lbl_e       lbl;
    } vec_t;

    typedef struct {
        logic [22:0] exp;
        logic        bne;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    // Expected outputs per state, transcribed from the controller's output table.
    function automatic logic [22:0] exp_out(lbl_e l, logic rdy);
        logic req = 0, io = 0, mw = 0, irw = 0, pcw = 0, br = 0, rw = 0, asa = 0, oi = 0, tr = 0;
        logic [1:0] asb = 0, pcs = 0, m2r = 0, rd = 0, tc = 0;
        logic [2:0] aop = 0;
        case (l)
            L_FETCH:  begin req = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            L_DECODE: asb = 2'b11;
            L_RTYPE:  begin asa = 1; aop = 3'b010; end
            L_ALUWB:  begin rd = 2'b01; rw = 1; end
            L_ADDI:   begin asa = 1; asb = 2'b10; end
            L_SLTI:   begin asa = 1; asb = 2'b10; aop = 3'b100; end
            L_ORI:    begin asa = 1; asb = 2'b10; aop = 3'b011; oi = 1; end
            L_IMMWB:  rw = 1;
            L_BEQ, L_BNE: begin asa = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
            L_J:      begin pcs = 2'b10; pcw = 1; end
            L_JAL:    begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; end
            L_JR:     begin asa = 1; pcs = 2'b11; pcw = 1; end
            L_MEMADR: begin asa = 1; asb = 2'b10; end
            L_MEMRD:  begin req = 1; io = 1; end
            L_MEMWB:  begin m2r = 2'b01; rw = 1; end
            L_MEMWR:  begin req = 1; io = 1; mw = 1; end
            L_TRAP1:  begin tr = 1; tc = 2'b01; end
            L_TRAP2:  begin tr = 1; tc = 2'b10; end
            default:  ;
        endcase
        return {req, io, mw, irw, pcw, br, rw, asa, oi, asb, pcs, m2r, rd, aop, tr, tc};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input lbl_e l);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.lbl = l;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [22:0] got, input logic [22:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_pop();
        sb_t e;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            return;
        end
        e = sbq.pop_front();
        chk(e.name, act, e.exp);
`ifdef MC_CTRL_BNE_EN
        chk({e.name, "_branch_ne"}, {22'd0, branch_ne}, {22'd0, e.bne});
`endif
    endtask

    // Inputs applied at the start of a cycle, outputs compared at the falling edge.
    task automatic step(input vec_t v);
        sb_t  e;
        lbl_e l;
        l = v.lbl;
        opcode = v.op; funct = v.fn; mem_ready = v.rdy;
        e.exp = exp_out(l, v.rdy); e.bne = (l == L_BNE); e.name = l.name();
        sbq.push_back(e);
        @(negedge clk);
        check_pop();
        @(posedge clk); #1;
    endtask

    task automatic reset_seq();
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset_outputs", act, 23'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        // add (opcode changes in ALUWB must be ignored)
        add(6'h00, 6'h20, 1, L_FETCH); add(6'h00, 6'h20, 1, L_DECODE);
        add(6'h00, 6'h20, 1, L_RTYPE); add(6'h3F, 6'h20, 1, L_ALUWB);
        // lw / sw / beq with zero-wait memory
        add(6'h23, 0, 1, L_FETCH); add(6'h23, 0, 1, L_DECODE); add(6'h23, 0, 1, L_MEMADR);
        add(6'h23, 0, 1, L_MEMRD); add(6'h23, 0, 1, L_MEMWB);
        add(6'h2B, 0, 1, L_FETCH); add(6'h2B, 0, 1, L_DECODE); add(6'h2B, 0, 1, L_MEMADR);
        add(6'h2B, 0, 1, L_MEMWR);
        add(6'h04, 0, 1, L_FETCH); add(6'h04, 0, 1, L_DECODE); add(6'h04, 0, 1, L_BEQ);
        // fetch with three wait states, then addi
        add(6'h08, 0, 0, L_FETCH); add(6'h08, 0, 0, L_FETCH); add(6'h08, 0, 0, L_FETCH);
        add(6'h08, 0, 1, L_FETCH); add(6'h08, 0, 1, L_DECODE); add(6'h08, 0, 1, L_ADDI);
        add(6'h08, 0, 1, L_IMMWB);
        add(6'h0A, 0, 1, L_FETCH); add(6'h0A, 0, 1, L_DECODE); add(6'h0A, 0, 1, L_SLTI);
        add(6'h0A, 0, 1, L_IMMWB);
        add(6'h0D, 0, 1, L_FETCH); add(6'h0D, 0, 1, L_DECODE); add(6'h0D, 0, 1, L_ORI);
        add(6'h0D, 0, 1, L_IMMWB);
        add(6'h02, 0, 1, L_FETCH); add(6'h02, 0, 1, L_DECODE); add(6'h02, 0, 1, L_J);
        add(6'h03, 0, 1, L_FETCH); add(6'h03, 0, 1, L_DECODE); add(6'h03, 0, 1, L_JAL);
        add(6'h00, 6'h08, 1, L_FETCH); add(6'h00, 6'h08, 1, L_DECODE); add(6'h00, 6'h08, 1, L_JR);
        add(6'h09, 0, 1, L_FETCH); add(6'h09, 0, 1, L_DECODE); add(6'h09, 0, 1, L_ADDI);
        add(6'h09, 0, 1, L_IMMWB);
        // lw whose ready arrives exactly on the timeout cycle
        add(6'h23, 0, 1, L_FETCH); add(6'h23, 0, 1, L_DECODE); add(6'h23, 0, 1, L_MEMADR);
        add(6'h23, 0, 0, L_MEMRD); add(6'h23, 0, 0, L_MEMRD); add(6'h23, 0, 0, L_MEMRD);
        add(6'h23, 0, 1, L_MEMRD); add(6'h23, 0, 1, L_MEMWB);
        // sw with two wait states
        add(6'h2B, 0, 1, L_FETCH); add(6'h2B, 0, 1, L_DECODE); add(6'h2B, 0, 1, L_MEMADR);
        add(6'h2B, 0, 0, L_MEMWR); add(6'h2B, 0, 0, L_MEMWR); add(6'h2B, 0, 1, L_MEMWR);
        // lw that never completes -> timeout trap, enables stay low
        add(6'h23, 0, 1, L_FETCH); add(6'h23, 0, 1, L_DECODE); add(6'h23, 0, 1, L_MEMADR);
        add(6'h23, 0, 0, L_MEMRD); add(6'h23, 0, 0, L_MEMRD); add(6'h23, 0, 0, L_MEMRD);
        add(6'h23, 0, 0, L_MEMRD); add(6'h23, 0, 0, L_TRAP2); add(6'h23, 0, 1, L_TRAP2);
        add(6'h00, 0, 1, L_TRAP2);
        add(0, 0, 0, L_RST);
        // illegal opcode
        add(6'h3F, 0, 1, L_FETCH); add(6'h3F, 0, 1, L_DECODE); add(6'h3F, 0, 1, L_TRAP1);
        add(6'h00, 0, 1, L_TRAP1);
        add(0, 0, 0, L_RST);
        // opcode 0x05
        add(6'h05, 0, 1, L_FETCH); add(6'h05, 0, 1, L_DECODE);
`ifdef MC_CTRL_BNE_EN
        add(6'h05, 0, 1, L_BNE); add(6'h05, 0, 1, L_FETCH);
`else
        add(6'h05, 0, 1, L_TRAP1);
`endif
        add(0, 0, 0, L_RST);
        // fetch that never completes
        add(0, 0, 0, L_FETCH); add(0, 0, 0, L_FETCH); add(0, 0, 0, L_FETCH);
        add(0, 0, 0, L_FETCH); add(0, 0, 0, L_TRAP2);
        add(0, 0, 0, L_RST);

        rst_n = 1'b0;
        #3;
        chk("reset_initial", act, 23'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.lbl == L_RST) reset_seq();
            else step(v);
        end

        // reset pulse during a stalled store
        add(6'h2B, 0, 1, L_FETCH); add(6'h2B, 0, 1, L_DECODE); add(6'h2B, 0, 1, L_MEMADR);
        add(6'h2B, 0, 0, L_MEMWR);
        for (int i = vecs.size() - 4; i < vecs.size(); i++) step(vecs[i]);
        mem_ready = 1'b0;
        #2;
        chk("memwr_stalled", {21'd0, mem_req, mem_write}, 23'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req_write", {21'd0, mem_req, mem_write}, 23'd0);
        chk("rst_all_outputs", act, 23'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        add(6'h00, 6'h20, 1, L_FETCH);
        step(vecs[vecs.size() - 1]);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl_hs.md
Name: mips_mc_ctrl_hs

Overview:
Parametrised multicycle MIPS main controller, successor to the current fixed-timing FSM controller. Adds a memory request/ready handshake with wait states, a bounded-wait timeout, and an illegal-opcode trap. Drives the datapath select/enable lines and sits between the instruction register decode fields and the multicycle datapath plus unified memory.

Parameters:
ALUOP_W, 3, width of alu_op; minimum 3.
MEM_TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before trapping; range 1..255.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
iord  out  1  0=PC address, 1=ALUOut address
mem_write  out  1  store strobe, valid with mem_req
ir_write  out  1  instruction register load
pc_write  out  1  unconditional PC load
branch  out  1  PC load qualified by ALU zero
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=rs
ori  out  1  zero-extend immediate
alu_src_b  out  2  00 rt, 01 const 4, 10 signext imm, 11 imm<<2
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (jal)
reg_dst  out  2  00 rt, 01 rd, 10 $31
alu_op  out  ALUOP_W  operation class for ALU decoder
trap  out  1  controller halted by error
trap_code  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (async, rst_n low): state=FETCH, wait counter=0, trap=0, trap_code=00. All outputs are Moore-decoded from state and registered trap info. Every enable (mem_req excepted in FETCH) is 0; every select is 0. No X on any output in any state.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. ir_write and pc_write are asserted only when mem_ready=1 (same cycle). Next state is DECODE on mem_ready, else FETCH.
  - DECODE: alu_src_b=11, alu_op=ADD. Dispatch: 0x00 -> funct 0x08 ? JR : RTYPE; 0x08/0x09 -> ADDI; 0x0A -> SLTI; 0x0D -> ORI; 0x04 -> BEQ; 0x02 -> J; 0x03 -> JAL; 0x23/0x2B -> MEMADR; else TRAP (code 01).
  - RTYPE: alu_src_a=1, alu_src_b=00, alu_op=FUNCT -> ALUWB.
  - ALUWB: reg_dst=01, mem_to_reg=00, reg_write=1 -> FETCH.
  - ADDI: alu_src_a=1, alu_src_b=10, alu_op=ADD -> IMMWB.
  - SLTI: same as ADDI but alu_op=SLT -> IMMWB.
  - ORI: same as ADDI but alu_op=OR and ori=1 -> IMMWB.
  - IMMWB: reg_dst=00, mem_to_reg=00, reg_write=1 -> FETCH.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, branch=1 -> FETCH.
  - J: pc_src=10, pc_write=1 -> FETCH.
  - JAL: J outputs plus reg_dst=10, mem_to_reg=10, reg_write=1 -> FETCH.
  - JR: alu_src_a=1, pc_src=11, pc_write=1 -> FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEMRD (0x23) or MEMWR (0x2B).
  - MEMRD: mem_req=1, iord=1. Leaves to MEMWB on mem_ready, else holds.
  - MEMWB: reg_dst=00, mem_to_reg=01, reg_write=1 -> FETCH.
  - MEMWR: mem_req=1, iord=1, mem_write=1. Leaves to FETCH on mem_ready, else holds.
  - TRAP: all enables 0, trap=1; held until reset.
- Wait counter:
  - Clears on entry to any memory state (FETCH, MEMRD, MEMWR) and increments each cycle in which mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with code 10.
  - If mem_ready=1 on the timeout cycle, the access completes normally; completion wins.
- Latency with zero-wait memory (mem_ready tied 1): R-type 4 cycles, load 5, store 4, branch/jump 3.
- opcode/funct are sampled only in DECODE, RTYPE/JR dispatch, and MEMADR; they may change elsewhere.
- Reset asserted mid-access drops mem_req asynchronously; no partial write strobe is extended.

Optional Feature:
MC_CTRL_BNE_EN
- Defined: opcode 0x05 dispatches to BNE state, identical to BEQ, plus output port branch_ne=1 (datapath inverts zero).
- Undefined: no branch_ne port; opcode 0x05 traps as illegal (code 01).

Decomposition:
- Package mc_ctrl_pkg holds: state encoding localparams; ALU op constants ADD=000, SUB=001, FUNCT=010, OR=011, SLT=100; opcode/funct constants; trap code constants; select encodings for pc_src, mem_to_reg, reg_dst, alu_src_b.
- One sub-module, mc_wait_timer: the wait counter plus timeout compare, parametrised by MEM_TIMEOUT.

Test Plan:
- mem_ready=1 constantly, program add / lw / sw / beq taken -> state sequences of 4/5/4/3 cycles; reg_write pulse in ALUWB and MEMWB only.
- Fetch with mem_ready low 3 cycles -> mem_req held 4 cycles; ir_write and pc_write one cycle, only on the ready cycle.
- MEM_TIMEOUT=4, lw with mem_ready never asserted -> trap=1, trap_code=10 after 4 stall cycles in MEMRD; enables stay 0 thereafter.
- mem_ready rises exactly on the timeout cycle -> access completes, no trap.
- opcode 0x3F -> TRAP, code 01; opcode 0x05 traps without MC_CTRL_BNE_EN, takes the BNE path with branch_ne=1 when it is defined.
- rst_n pulsed low during MEMWR stall -> mem_write and mem_req drop immediately; after release, FETCH with trap=0.
